dog_align_diff: RTL and testbench

DOG_ALIGN_DIFF -- requirements
Module: dog_align_diff

---
 rtl/dog_align_diff.sv | 141 ++++++++++++++
 tb/tb_dog_align_diff.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_align_diff.sv
// Difference-of-Gaussians alignment and difference stage.
// Each scale k < NUM_SCALES-1 is delayed through a circular line of DELAY
// samples so that it lines up with scale k+1. Difference k is then computed
// as tap_k - g_{k+1}, shifted left by SHIFT, and reduced to DATA_W bits
// according to MODE.
module dog_align_diff #(
  parameter int unsigned NUM_SCALES = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DELAY      = 1272,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned MODE       = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_SCALES*DATA_W-1:0]     g_din,
  input  logic [NUM_SCALES-1:0]            g_valid,
  input  logic [NUM_SCALES-1:0]            g_blank,
  output logic [(NUM_SCALES-1)*DATA_W-1:0] d_dout,
  output logic [NUM_SCALES-2:0]            d_valid,
  output logic [NUM_SCALES-2:0]            d_blank,
  output logic [NUM_SCALES-2:0]            primed
);

  localparam int unsigned NUM_DIFF = NUM_SCALES - 1;
  localparam int unsigned PTR_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned CNT_W    = $clog2(DELAY + 1);
  localparam int unsigned DIFF_W   = DATA_W + 1;
  localparam int unsigned WIDE_W   = DATA_W + SHIFT + 1;

  // Clamp limits expressed in the widened difference width.
  localparam logic signed [WIDE_W-1:0] S_MAX =
    {{(SHIFT + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] S_MIN =
    {{(SHIFT + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic [WIDE_W-1:0] U_MAX =
    {{(SHIFT + 1){1'b0}}, {DATA_W{1'b1}}};

  // Scale 0 blanking never reaches a difference; only scales 1.. qualify outputs.
  logic blank0_unused;
  assign blank0_unused = g_blank[0];

  for (genvar k = 0; k < NUM_DIFF; k++) begin : g_lane
    logic [DATA_W-1:0]        mem [DELAY];
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         fill;
    logic [DATA_W-1:0]        tap;
    logic                     primed_q;
    logic [DATA_W-1:0]        dout_q;
    logic                     valid_q;
    logic                     blank_q;
    logic                     push;
    logic                     upd;
    logic [DATA_W-1:0]        push_px;
    logic [DATA_W-1:0]        sub_px;
    logic signed [DIFF_W-1:0] diff;
    logic signed [WIDE_W-1:0] diff_sh;
    logic [WIDE_W-1:0]        mag;
    logic [DATA_W-1:0]        red;

    assign push    = g_valid[k] & ~flush;
    assign upd     = g_valid[k+1] & ~flush;
    assign push_px = g_din[k*DATA_W +: DATA_W];
    assign sub_px  = g_din[(k+1)*DATA_W +: DATA_W];

    // Delay-line storage: written at the pointer after its old content is read.
    always_ff @(posedge clock) begin
      if (push) begin
        mem[wr_ptr] <= push_px;
      end
    end

    // Pointer, fill counter, tap and primed flag for this line.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr   <= '0;
        fill     <= '0;
        tap      <= '0;
        primed_q <= 1'b0;
      end else if (flush) begin
        wr_ptr   <= '0;
        fill     <= '0;
        primed_q <= 1'b0;
      end else if (push) begin
        tap    <= mem[wr_ptr];
        wr_ptr <= (wr_ptr == PTR_W'(DELAY - 1)) ? '0 : wr_ptr + PTR_W'(1);
        if (fill != CNT_W'(DELAY)) begin
          fill <= fill + CNT_W'(1);
        end
        if (fill >= CNT_W'(DELAY - 1)) begin
          primed_q <= 1'b1;
        end
      end
    end

    // Signed difference, left shift and MODE reduction to DATA_W bits.
    always_comb begin
      red     = '0;
      mag     = '0;
      diff    = $signed({1'b0, tap}) - $signed({1'b0, sub_px});
      diff_sh = WIDE_W'(diff) <<< SHIFT;
      if (MODE == 0) begin
        red = diff_sh[DATA_W-1:0];
      end else if (MODE == 1) begin
        if (diff_sh > S_MAX) begin
          red = S_MAX[DATA_W-1:0];
        end else if (diff_sh < S_MIN) begin
          red = S_MIN[DATA_W-1:0];
        end else begin
          red = diff_sh[DATA_W-1:0];
        end
      end else begin
        mag = diff_sh[WIDE_W-1] ? $unsigned(-diff_sh) : $unsigned(diff_sh);
        red = (mag > U_MAX) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
      end
    end

    // Difference output register: updates on g_valid[k+1], strobe otherwise low.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
        blank_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (upd) begin
        dout_q  <= red;
        blank_q <= g_blank[k+1];
        valid_q <= primed_q & ~g_blank[k+1];
      end else begin
        valid_q <= 1'b0;
      end
    end

    assign d_dout[k*DATA_W +: DATA_W] = dout_q;
    assign d_valid[k]                 = valid_q;
    assign d_blank[k]                 = blank_q;
    assign primed[k]                  = primed_q;
  end

endmodule

// File: tb/tb_dog_align_diff.sv
// Self-checking bench for dog_align_diff: vector table for the reduction
// modes, directed sequences for priming, blanking, wrap, flush and async
// reset, and a randomized run against a queue-based reference model.
module tb_dog_align_diff;

  localparam int DW      = 8;
  localparam int A_DELAY = 4;
  localparam int S_DELAY = 2;
  localparam int R_NS    = 5;
  localparam int R_DELAY = 4;
  localparam int R_SHIFT = 1;
  localparam int R_MODE  = 2;

  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int seen;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Instance A: 2 scales, DELAY 4, no shift, signed saturate.
  logic          a_flush;
  logic [2*DW-1:0] a_din;
  logic [1:0]    a_valid, a_blank;
  logic [DW-1:0] a_dout;
  logic [0:0]    a_dv, a_db, a_pr;

  dog_align_diff #(.NUM_SCALES(2), .DATA_W(DW), .DELAY(A_DELAY), .SHIFT(0), .MODE(1)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush), .g_din(a_din),
    .g_valid(a_valid), .g_blank(a_blank), .d_dout(a_dout),
    .d_valid(a_dv), .d_blank(a_db), .primed(a_pr));

  // Instances S: one per MODE, shared stimulus, SHIFT 4.
  logic          s_flush;
  logic [2*DW-1:0] s_din;
  logic [1:0]    s_valid, s_blank;
  logic [DW-1:0] s_dout [3];
  logic [0:0]    s_dv [3];
  logic [0:0]    s_db [3];
  logic [0:0]    s_pr [3];

  for (genvar m = 0; m < 3; m++) begin : g_sat
    dog_align_diff #(.NUM_SCALES(2), .DATA_W(DW), .DELAY(S_DELAY), .SHIFT(4), .MODE(m)) u_s (
      .clock(clock), .reset(reset), .flush(s_flush), .g_din(s_din),
      .g_valid(s_valid), .g_blank(s_blank), .d_dout(s_dout[m]),
      .d_valid(s_dv[m]), .d_blank(s_db[m]), .primed(s_pr[m]));
  end

  // Instance R: 5 scales, randomized against the reference model.
  logic                  r_flush;
  logic [R_NS*DW-1:0]    r_din;
  logic [R_NS-1:0]       r_valid, r_blank;
  logic [(R_NS-1)*DW-1:0] r_dout;
  logic [R_NS-2:0]       r_dv, r_db, r_pr;

  dog_align_diff #(.NUM_SCALES(R_NS), .DATA_W(DW), .DELAY(R_DELAY), .SHIFT(R_SHIFT), .MODE(R_MODE)) u_r (
    .clock(clock), .reset(reset), .flush(r_flush), .g_din(r_din),
    .g_valid(r_valid), .g_blank(r_blank), .d_dout(r_dout),
    .d_valid(r_dv), .d_blank(r_db), .primed(r_pr));

  typedef struct {
    logic [7:0] tap;
    logic [7:0] g;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } sat_vec_t;

  sat_vec_t sv [6];

  // Reference model state: last DELAY+1 pushes per line kept in a queue.
  int m_hist [R_NS-1][$];
  int m_npush [R_NS-1];
  int m_tap [R_NS-1];
  bit m_tap_ok [R_NS-1];
  int m_dout [R_NS-1];
  bit m_dout_ok [R_NS-1];
  bit m_dv [R_NS-1];
  bit m_db [R_NS-1];
  bit m_pr [R_NS-1];

  function automatic int ref_reduce(input int d, input int mode, input int sh);
    int v;
    int lim;
    v = d * (2 ** sh);
    lim = 2 ** (DW - 1);
    if (mode == 0) return v & ((2 ** DW) - 1);
    if (mode == 1) begin
      if (v > lim - 1) v = lim - 1;
      if (v < -lim) v = -lim;
      return v & ((2 ** DW) - 1);
    end
    if (v < 0) v = -v;
    if (v > (2 ** DW) - 1) v = (2 ** DW) - 1;
    return v;
  endfunction

  task automatic a_cyc(input logic push, input logic [7:0] v0, input logic upd,
                       input logic [7:0] v1, input logic blk1, input logic fl);
    a_valid = {upd, push};
    a_din   = {v1, v0};
    a_blank = {blk1, 1'b0};
    a_flush = fl;
    @(posedge clock);
    #1;
    a_valid = '0;
    a_blank = '0;
    a_flush = 1'b0;
  endtask

  task automatic s_cyc(input logic push, input logic [7:0] v0, input logic upd,
                       input logic [7:0] v1, input logic fl);
    s_valid = {upd, push};
    s_din   = {v1, v0};
    s_blank = '0;
    s_flush = fl;
    @(posedge clock);
    #1;
    s_valid = '0;
    s_flush = 1'b0;
  endtask

  task automatic model_step();
    for (int k = 0; k < R_NS - 1; k++) begin
      int g_hi;
      int px;
      g_hi = int'(r_din[(k+1)*DW +: DW]);
      px   = int'(r_din[k*DW +: DW]);
      if (r_flush) begin
        m_dv[k]    = 1'b0;
        m_pr[k]    = 1'b0;
        m_npush[k] = 0;
        m_hist[k].delete();
      end else begin
        if (r_valid[k+1]) begin
          m_dv[k] = m_pr[k] && !r_blank[k+1];
          m_db[k] = r_blank[k+1];
          if (m_tap_ok[k]) begin
            m_dout[k]    = ref_reduce(m_tap[k] - g_hi, R_MODE, R_SHIFT);
            m_dout_ok[k] = 1'b1;
          end else begin
            m_dout_ok[k] = 1'b0;
          end
        end else begin
          m_dv[k] = 1'b0;
        end
        if (r_valid[k]) begin
          if (m_hist[k].size() == R_DELAY + 1) void'(m_hist[k].pop_front());
          m_hist[k].push_back(px);
          m_npush[k]++;
          if (m_hist[k].size() == R_DELAY + 1) begin
            m_tap[k]    = m_hist[k][0];
            m_tap_ok[k] = 1'b1;
          end else begin
            m_tap_ok[k] = 1'b0;
          end
          m_pr[k] = (m_npush[k] >= R_DELAY);
        end
      end
    end
  endtask

  task automatic r_cyc();
    model_step();
    @(posedge clock);
    #1;
    for (int k = 0; k < R_NS - 1; k++) begin
      check($sformatf("rnd_primed%0d", k), int'(r_pr[k]), int'(m_pr[k]));
      check($sformatf("rnd_valid%0d", k), int'(r_dv[k]), int'(m_dv[k]));
      check($sformatf("rnd_blank%0d", k), int'(r_db[k]), int'(m_db[k]));
      if (m_dout_ok[k])
        check($sformatf("rnd_dout%0d", k), int'(r_dout[k*DW +: DW]), m_dout[k]);
    end
  endtask

  task automatic r_randomize(input bit force_flush);
    r_flush = force_flush || ($urandom_range(0, 99) == 0);
    for (int j = 0; j < R_NS; j++) begin
      r_valid[j] = ($urandom_range(0, 9) < 6);
      r_blank[j] = ($urandom_range(0, 4) == 0);
    end
    r_din = 40'({$urandom(), $urandom()});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected to finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    sv[0] = '{8'd200, 8'd10,  8'hE0, 8'h7F, 8'hFF};
    sv[1] = '{8'd0,   8'd255, 8'h10, 8'h80, 8'hFF};
    sv[2] = '{8'd100, 8'd100, 8'h00, 8'h00, 8'h00};
    sv[3] = '{8'd5,   8'd3,   8'h20, 8'h20, 8'h20};
    sv[4] = '{8'd3,   8'd5,   8'hE0, 8'hE0, 8'h20};
    sv[5] = '{8'd12,  8'd4,   8'h80, 8'h7F, 8'h80};

    reset   = 1'b1;
    a_flush = 1'b0; a_din = '0; a_valid = '0; a_blank = '0;
    s_flush = 1'b0; s_din = '0; s_valid = '0; s_blank = '0;
    r_flush = 1'b0; r_din = '0; r_valid = '0; r_blank = '0;

    // Reset state while reset is held across clock edges.
    repeat (2) @(posedge clock);
    #1;
    check("reset_dout", int'(a_dout), 0);
    check("reset_valid", int'(a_dv), 0);
    check("reset_blank", int'(a_db), 0);
    check("reset_primed", int'(a_pr), 0);
    check("reset_r_dout", int'(r_dout[31:0]), 0);
    check("reset_r_primed", int'(r_pr), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Reduction modes: prime a DELAY-2 line so that tap holds the wanted value.
    for (int i = 0; i < 6; i++) begin
      s_cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
      s_cyc(1'b1, sv[i].tap, 1'b0, 8'd0, 1'b0);
      s_cyc(1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
      s_cyc(1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
      s_cyc(1'b0, 8'd0, 1'b1, sv[i].g, 1'b0);
      check($sformatf("sat%0d_mode0", i), int'(s_dout[0]), int'(sv[i].e0));
      check($sformatf("sat%0d_mode1", i), int'(s_dout[1]), int'(sv[i].e1));
      check($sformatf("sat%0d_mode2", i), int'(s_dout[2]), int'(sv[i].e2));
      for (int m = 0; m < 3; m++) begin
        check($sformatf("sat%0d_valid_m%0d", i, m), int'(s_dv[m]), 1);
        check($sformatf("sat%0d_primed_m%0d", i, m), int'(s_pr[m]), 1);
        check($sformatf("sat%0d_blank_m%0d", i, m), int'(s_db[m]), 0);
      end
    end

    // Priming: primed rises after the 4th push.
    a_cyc(1'b1, 8'd10, 1'b0, 8'd0, 1'b0, 1'b0);
    check("prime_p1", int'(a_pr), 0);
    a_cyc(1'b1, 8'd20, 1'b0, 8'd0, 1'b0, 1'b0);
    check("prime_p2", int'(a_pr), 0);
    a_cyc(1'b1, 8'd30, 1'b0, 8'd0, 1'b0, 1'b0);
    check("prime_p3", int'(a_pr), 0);
    a_cyc(1'b1, 8'd40, 1'b0, 8'd0, 1'b0, 1'b0);
    check("prime_p4", int'(a_pr), 1);
    // 5th push with an update: strobe asserts; tap before this edge predates the frame.
    a_cyc(1'b1, 8'd50, 1'b1, 8'd5, 1'b0, 1'b0);
    check("prime_valid5", int'(a_dv), 1);
    // 5th push loaded tap=10, so the next update gives 10-5.
    a_cyc(1'b0, 8'd0, 1'b1, 8'd5, 1'b0, 1'b0);
    check("prime_dout", int'(a_dout), 5);
    check("prime_valid", int'(a_dv), 1);
    a_cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("idle_valid", int'(a_dv), 0);
    check("idle_hold", int'(a_dout), 5);

    // Blanking: output updates, strobe suppressed, flag registered.
    a_cyc(1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0);
    check("blank_dout", int'(a_dout), 7);
    check("blank_valid", int'(a_dv), 0);
    check("blank_flag", int'(a_db), 1);
    a_cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("blank_hold_valid", int'(a_dv), 0);
    check("blank_hold_dout", int'(a_dout), 7);
    check("blank_hold_flag", int'(a_db), 1);

    // Flush, then a 3*DELAY+1 ramp with an update on every push.
    a_cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("flush1_primed", int'(a_pr), 0);
    check("flush1_hold", int'(a_dout), 7);
    for (int j = 0; j < 3 * A_DELAY + 1; j++) begin
      a_cyc(1'b1, 8'(j + 1), 1'b1, 8'd0, 1'b0, 1'b0);
      check($sformatf("wrap_valid%0d", j), int'(a_dv), int'(j >= A_DELAY));
      if (j >= A_DELAY + 1)
        check($sformatf("wrap_tap%0d", j), int'(a_dout), j - A_DELAY);
    end

    // Flush with inputs presented: they are discarded.
    a_cyc(1'b1, 8'd77, 1'b1, 8'd0, 1'b0, 1'b1);
    check("flush2_primed", int'(a_pr), 0);
    check("flush2_valid", int'(a_dv), 0);
    for (int j = 0; j < A_DELAY; j++) begin
      a_cyc(1'b1, 8'(100 + j), 1'b1, 8'd0, 1'b0, 1'b0);
      check($sformatf("refill_valid%0d", j), int'(a_dv), 0);
      check($sformatf("refill_primed%0d", j), int'(a_pr), int'(j == A_DELAY - 1));
    end

    // Independence: only scales 0 and 1 active on the 5-scale instance.
    seen = 0;
    r_blank = '0;
    for (int c = 0; c < 60; c++) begin
      r_valid = {3'b000, 2'($urandom_range(0, 3))};
      r_din   = 40'({$urandom(), $urandom()});
      @(posedge clock);
      #1;
      check("indep_valid_hi", int'(r_dv[3:1]), 0);
      check("indep_dout_hi", int'(r_dout[31:8]), 0);
      if (r_dv[0]) seen++;
    end
    r_valid = '0;
    check("indep_valid0_seen", int'(seen > 0), 1);

    // Randomized run against the reference model, starting with a flush.
    for (int k = 0; k < R_NS - 1; k++) begin
      m_hist[k].delete();
      m_npush[k]   = 0;
      m_tap[k]     = 0;
      m_tap_ok[k]  = (k >= 2);
      m_dout[k]    = 0;
      m_dout_ok[k] = (k >= 1);
      m_dv[k]      = 1'b0;
      m_db[k]      = 1'b0;
      m_pr[k]      = 1'b0;
    end
    r_randomize(1'b1);
    r_cyc();
    for (int c = 0; c < 1500; c++) begin
      r_randomize(1'b0);
      r_cyc();
    end
    r_valid = '0;
    r_flush = 1'b0;

    // Async reset mid-frame on the primed instance A.
    a_cyc(1'b1, 8'd104, 1'b0, 8'd0, 1'b0, 1'b0);
    a_cyc(1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);
    check("rst_pre_dout", int'(a_dout), 99);
    check("rst_pre_valid", int'(a_dv), 1);
    a_cyc(1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0);
    check("rst_pre_blank", int'(a_db), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_dout", int'(a_dout), 0);
    check("rst_async_valid", int'(a_dv), 0);
    check("rst_async_blank", int'(a_db), 0);
    check("rst_async_primed", int'(a_pr), 0);
    @(posedge clock);
    #1;
    check("rst_held_primed", int'(a_pr), 0);
    check("rst_held_dout", int'(a_dout), 0);
    #2 reset = 1'b0;
    for (int j = 0; j < A_DELAY; j++) begin
      a_cyc(1'b1, 8'(j), 1'b0, 8'd0, 1'b0, 1'b0);
      check($sformatf("rst_refill%0d", j), int'(a_pr), int'(j == A_DELAY - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
